// File: rtl/prefetch_ctrl.sv
// Instruction prefetch controller: sequential fetch into a small FIFO with redirect flush.
// Optional perf counters (stall_cycles, redirect_cnt) are built when PREFETCH_PERF_CNT_EN is defined.
module prefetch_ctrl #(
   parameter int unsigned              ADDRESS_WIDTH = 32,
   parameter int unsigned              DATA_WIDTH    = 32,
   parameter int unsigned              DEPTH         = 4,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       redirect_valid,
   input  logic [ADDRESS_WIDTH-1:0]   redirect_pc,
   output logic [ADDRESS_WIDTH-1:0]   imem_addr,
   input  logic [DATA_WIDTH-1:0]      imem_dout,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_WIDTH-1:0]      out_instr,
   output logic [ADDRESS_WIDTH-1:0]   out_pc,
`ifdef PREFETCH_PERF_CNT_EN
   output logic [31:0]                stall_cycles,
   output logic [31:0]                redirect_cnt,
`endif
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      FULL  = 2'd2
   } state_e;

   state_e                   state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]         count_q, count_d;
   logic [ADDRESS_WIDTH-1:0] pc_mem    [DEPTH];
   logic [DATA_WIDTH-1:0]    instr_mem [DEPTH];
   logic                     full;
   logic                     pop;
   logic                     push;
   logic [ADDRESS_WIDTH-1:0] redirect_pc_aligned;

   assign full                = (count_q == CNT_W'(DEPTH));
   assign out_valid           = (count_q != '0);
   assign out_pc              = pc_mem[rd_ptr_q];
   assign out_instr           = instr_mem[rd_ptr_q];
   assign count               = count_q;
   assign imem_addr           = fetch_pc_q >> 2;
   assign redirect_pc_aligned = redirect_pc & ~ADDRESS_WIDTH'(3);
   // A redirect swallows the consumer handshake of its own cycle.
   assign pop                 = out_valid && out_ready && !redirect_valid;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path can infer a latch.
      push       = 1'b0;
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      case (state_q)
         IDLE:    state_d = FETCH;
         FETCH: begin
            push = !full || pop;
            if (full && !pop) state_d = FULL;
         end
         FULL:    if (pop) state_d = FETCH;
         default: state_d = IDLE;
      endcase
      if (push) fetch_pc_d = fetch_pc_q + ADDRESS_WIDTH'(4);
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      if (redirect_valid) begin
         push       = 1'b0;
         state_d    = FETCH;
         fetch_pc_d = redirect_pc_aligned;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; count_q gates visibility of stale entries.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr_q]    <= fetch_pc_q;
         instr_mem[wr_ptr_q] <= imem_dout;
      end
   end

`ifdef PREFETCH_PERF_CNT_EN
   logic [31:0] stall_cycles_q;
   logic [31:0] redirect_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles_q <= '0;
         redirect_cnt_q <= '0;
      end else begin
         if (state_q == FULL && stall_cycles_q != '1) stall_cycles_q <= stall_cycles_q + 32'd1;
         if (redirect_valid) redirect_cnt_q <= redirect_cnt_q + 32'd1;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign redirect_cnt = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_prefetch_ctrl.sv
// Self-checking bench for prefetch_ctrl: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the prefetch rules.
module tb_prefetch_ctrl;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          redirect_valid;
   logic [AW-1:0] redirect_pc;
   logic [AW-1:0] imem_addr;
   logic [DW-1:0] imem_dout;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_instr;
   logic [AW-1:0] out_pc;
   logic [2:0]    count;
`ifdef PREFETCH_PERF_CNT_EN
   logic [31:0]   stall_cycles;
   logic [31:0]   redirect_cnt;
`endif

   logic [31:0] key;
   int          checks = 0;
   int          errors = 0;

   // Reference model: buffered entries in order, next fetch address, and run flags.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;
   entry_t      m_q[$];
   logic [31:0] m_fetch_pc;
   bit          m_running;
   bit          m_stalled;

   always #5 clk = ~clk;

   // Memory word i holds i, optionally scrambled by key.
   assign imem_dout = imem_addr ^ key;

   prefetch_ctrl #(
      .ADDRESS_WIDTH(AW),
      .DATA_WIDTH   (DW),
      .DEPTH        (DEPTH),
      .RESET_PC     (32'h0)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .imem_addr     (imem_addr),
      .imem_dout     (imem_dout),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_instr     (out_instr),
      .out_pc        (out_pc),
`ifdef PREFETCH_PERF_CNT_EN
      .stall_cycles  (stall_cycles),
      .redirect_cnt  (redirect_cnt),
`endif
      .count         (count)
   );

   function automatic void model_tick(input bit r, input bit rv, input logic [31:0] rpc, input bit rdy);
      bit     do_pop;
      bit     do_push;
      int     size_before;
      entry_t e;
      if (r) begin
         m_q.delete();
         m_fetch_pc = 32'h0;
         m_running  = 1'b0;
         m_stalled  = 1'b0;
         return;
      end
      if (rv) begin
         m_q.delete();
         m_fetch_pc = rpc & ~32'h3;
         m_running  = 1'b1;
         m_stalled  = 1'b0;
         return;
      end
      if (!m_running) begin
         m_running = 1'b1;
         return;
      end
      size_before = m_q.size();
      do_pop  = (size_before != 0) && rdy;
      do_push = !m_stalled && ((size_before < DEPTH) || do_pop);
      e.pc    = m_fetch_pc;
      e.instr = (m_fetch_pc >> 2) ^ key;
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
         m_q.push_back(e);
         m_fetch_pc = m_fetch_pc + 32'd4;
      end
      m_stalled = (size_before == DEPTH) && !do_pop;
   endfunction

   function automatic logic [99:0] model_view();
      logic [31:0] p   = 32'h0;
      logic [31:0] ins = 32'h0;
      if (m_q.size() != 0) begin
         p   = m_q[0].pc;
         ins = m_q[0].instr;
      end
      return {m_q.size() != 0, 3'(m_q.size()), m_fetch_pc >> 2, p, ins};
   endfunction

   function automatic logic [99:0] obs_view();
      return {out_valid, count, imem_addr,
              out_valid ? out_pc : 32'h0, out_valid ? out_instr : 32'h0};
   endfunction

   // Drive one cycle's inputs, let the edge happen, advance the model, settle.
   task automatic tick(input bit r, input bit rv, input logic [31:0] rpc, input bit rdy);
      rst = r; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
      @(posedge clk);
      model_tick(r, rv, rpc, rdy);
      #1;
   endtask

   task automatic test_reset();
      tick(1'b1, 1'b0, 32'h0, 1'b0);
      tick(1'b1, 1'b0, 32'h0, 1'b0);
      checks++;
      if (count !== 3'd0 || out_valid !== 1'b0 || imem_addr !== 32'h0) begin
         errors++;
         $display("FAIL reset_state: count=%0d out_valid=%b imem_addr=%h, expected 0/0/0",
                  count, out_valid, imem_addr);
      end
      tick(1'b0, 1'b0, 32'h0, 1'b0);
      checks++;
      if (out_valid !== 1'b0 || imem_addr !== 32'h0) begin
         errors++;
         $display("FAIL reset_first_fetch: out_valid=%b imem_addr=%h, expected 0/0", out_valid, imem_addr);
      end
   endtask

   task automatic test_stream();
      tick(1'b1, 1'b0, 32'h0, 1'b1);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL stream_cycle0_valid: got %b expected 0", out_valid);
      end
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL stream_cycle1_valid: got %b expected 0", out_valid);
      end
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 12; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_pc !== 32'(4 * i) || out_instr !== 32'(i)) begin
            errors++;
            $display("FAIL stream_seq[%0d]: valid=%b pc=%h instr=%h, expected 1 pc=%h instr=%h",
                     i, out_valid, out_pc, out_instr, 32'(4 * i), 32'(i));
         end
         tick(1'b0, 1'b0, 32'h0, 1'b1);
      end
   endtask

   task automatic test_stall();
      tick(1'b1, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 32'h0, 1'b0);
      checks++;
      if (count !== 3'd4 || imem_addr !== 32'd4 || out_valid !== 1'b1 || out_pc !== 32'h0) begin
         errors++;
         $display("FAIL stall_full: count=%0d imem_addr=%h valid=%b pc=%h, expected 4/4/1/0",
                  count, imem_addr, out_valid, out_pc);
      end
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      checks++;
      if (count !== 3'd3 || imem_addr !== 32'd4 || out_pc !== 32'h4) begin
         errors++;
         $display("FAIL stall_first_pop: count=%0d imem_addr=%h pc=%h, expected 3/4/4",
                  count, imem_addr, out_pc);
      end
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      checks++;
      if (count !== 3'd3 || imem_addr !== 32'd5 || out_pc !== 32'h8) begin
         errors++;
         $display("FAIL stall_resume: count=%0d imem_addr=%h pc=%h, expected 3/5/8",
                  count, imem_addr, out_pc);
      end
   endtask

   task automatic test_redirect();
      tick(1'b1, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 32'h0, 1'b0);
      checks++;
      if (count !== 3'd3) begin
         errors++;
         $display("FAIL redirect_prefill: count=%0d expected 3", count);
      end
      tick(1'b0, 1'b1, 32'h103, 1'b1);
      checks++;
      if (count !== 3'd0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL redirect_flush: count=%0d valid=%b, expected 0/0", count, out_valid);
      end
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== ((32'h100 >> 2) ^ key)) begin
         errors++;
         $display("FAIL redirect_target: valid=%b pc=%h instr=%h, expected 1 pc=00000100 instr=%h",
                  out_valid, out_pc, out_instr, (32'h100 >> 2) ^ key);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_pcs [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
      tick(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_pc !== exp_pcs[i]) begin
            errors++;
            $display("FAIL wrap_seq[%0d]: valid=%b pc=%h, expected 1 pc=%h", i, out_valid, out_pc, exp_pcs[i]);
         end
         tick(1'b0, 1'b0, 32'h0, 1'b1);
      end
   endtask

   task automatic test_back_to_back();
      tick(1'b1, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 32'h0, 1'b0);
      checks++;
      if (count !== 3'd4 || out_pc !== 32'h0) begin
         errors++;
         $display("FAIL b2b_fill: count=%0d pc=%h, expected 4/0", count, out_pc);
      end
      for (int i = 0; i < 8; i++) begin
         tick(1'b0, 1'b0, 32'h0, 1'b1);
         checks++;
         if (count !== 3'd4 || out_pc !== 32'(4 * (i + 1))) begin
            errors++;
            $display("FAIL b2b_step[%0d]: count=%0d pc=%h, expected 4 pc=%h", i, count, out_pc, 32'(4 * (i + 1)));
         end
      end
   endtask

   task automatic test_reset_priority();
      tick(1'b1, 1'b1, 32'h500, 1'b1);
      checks++;
      if (imem_addr !== 32'h0 || count !== 3'd0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_over_redirect: imem_addr=%h count=%0d valid=%b, expected 0/0/0",
                  imem_addr, count, out_valid);
      end
`ifdef PREFETCH_PERF_CNT_EN
      checks++;
      if (redirect_cnt !== 32'h0) begin
         errors++;
         $display("FAIL rst_redirect_cnt: got %0d expected 0", redirect_cnt);
      end
`endif
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      checks++;
      if (imem_addr !== 32'h0) begin
         errors++;
         $display("FAIL rst_idle_pc: imem_addr=%h expected 0", imem_addr);
      end
   endtask

   task automatic test_idle_redirect();
      tick(1'b1, 1'b0, 32'h0, 1'b1);
      tick(1'b0, 1'b1, 32'h206, 1'b1);
      checks++;
      if (imem_addr !== 32'h81 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL idle_redirect_pc: imem_addr=%h valid=%b, expected 81/0", imem_addr, out_valid);
      end
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h204) begin
         errors++;
         $display("FAIL idle_redirect_head: valid=%b pc=%h, expected 1/204", out_valid, out_pc);
      end
   endtask

   task automatic test_random();
      bit          r;
      bit          rv;
      bit          rdy;
      logic [31:0] rpc;
      key = $urandom;
      for (int i = 0; i < 600; i++) begin
         r   = ($urandom_range(0, 79) == 0);
         rv  = ($urandom_range(0, 15) == 0);
         rpc = $urandom;
         rdy = (i < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         tick(r, rv, rpc, rdy);
         checks++;
         if (obs_view() !== model_view()) begin
            errors++;
            $display("FAIL random[%0d]: {valid,count,imem_addr,pc,instr} got %h expected %h",
                     i, obs_view(), model_view());
         end
      end
   endtask

   initial begin
      key = 32'h0;
      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
      test_reset();
      test_stream();
      test_stall();
      key = 32'hA5A5_0F0F;
      test_redirect();
      test_wrap();
      test_back_to_back();
      test_reset_priority();
      test_idle_redirect();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
